// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tracks renamed uops by sqN, retires completed ones oldest-first, squashes on mispredict.
// Optional build macro ROB_PERF_CNT_EN adds retired-uop and flush counters.
module reorder_buffer #(
    parameter int DEPTH        = 64,
    parameter int WIDTH_ISSUE  = 4,
    parameter int WIDTH_WB     = 4,
    parameter int WIDTH_COMMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH_ISSUE-1:0]    IN_uopValid,
    input  logic [WIDTH_ISSUE*7-1:0]  IN_uopSqN,
    input  logic [WIDTH_ISSUE*5-1:0]  IN_uopNmDst,
    input  logic [WIDTH_ISSUE*7-1:0]  IN_uopTagDst,
    input  logic [WIDTH_WB-1:0]       IN_wbValid,
    input  logic [WIDTH_WB*7-1:0]     IN_wbSqN,
    input  logic                      IN_branchTaken,
    input  logic [6:0]                IN_branchSqN,
    output logic [WIDTH_COMMIT-1:0]   OUT_comValid,
    output logic [WIDTH_COMMIT*5-1:0] OUT_comNmDst,
    output logic [WIDTH_COMMIT*7-1:0] OUT_comTagDst,
    output logic [WIDTH_COMMIT*7-1:0] OUT_comSqN,
    output logic [6:0]                OUT_maxSqN,
    output logic                      OUT_stall
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]               OUT_perfCommitted,
    output logic [31:0]               OUT_perfFlushes
`endif
);
    localparam int IDX = $clog2(DEPTH);

    function automatic logic is_younger(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = a - b;
        return !d[6] && (d != 7'd0);
    endfunction

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] done_reg;
    logic [4:0]       nm_mem  [DEPTH];
    logic [6:0]       tag_mem [DEPTH];
    logic [6:0]       base_sqn_reg;
    logic [6:0]       next_sqn_reg;
    logic             stall_reg;

    logic [WIDTH_COMMIT-1:0]   com_valid_reg;
    logic [WIDTH_COMMIT*5-1:0] com_nm_reg;
    logic [WIDTH_COMMIT*7-1:0] com_tag_reg;
    logic [WIDTH_COMMIT*7-1:0] com_sqn_reg;

    logic [WIDTH_COMMIT-1:0] com_ok;
    logic [6:0]              com_sqn [WIDTH_COMMIT];
    logic [6:0]              com_count;
    logic [6:0]              base_sqn_next;
    logic [6:0]              next_sqn_next;
    logic                    stall_next;

    logic [DEPTH-1:0] iss_hit;
    logic [DEPTH-1:0] wb_hit;
    logic [DEPTH-1:0] ret_hit;
    logic [DEPTH-1:0] squash;
    logic [4:0]       iss_nm  [DEPTH];
    logic [6:0]       iss_tag [DEPTH];
    logic             wb_unused;

    assign wb_unused = ^IN_wbSqN;

    // Oldest-first scan; stops at the first entry that cannot retire.
    always_comb begin
        logic alive;
        logic [IDX-1:0] slot;
        alive     = 1'b1;
        com_count = 7'd0;
        com_ok    = '0;
        for (int k = 0; k < WIDTH_COMMIT; k++) begin
            com_sqn[k] = base_sqn_reg + 7'(k);
            slot       = com_sqn[k][IDX-1:0];
            com_ok[k]  = alive && valid_reg[slot] && done_reg[slot] &&
                         (!IN_branchTaken || !is_younger(com_sqn[k], IN_branchSqN));
            alive      = com_ok[k];
            com_count  = com_count + 7'(com_ok[k]);
        end
    end

    always_comb begin
        logic [IDX-1:0] slot;
        iss_hit = '0;
        wb_hit  = '0;
        ret_hit = '0;
        slot    = '0;
        for (int e = 0; e < DEPTH; e++) begin
            iss_nm[e]  = 5'd0;
            iss_tag[e] = 7'd0;
        end
        for (int i = 0; i < WIDTH_ISSUE; i++) begin
            if (IN_uopValid[i]) begin
                slot          = IN_uopSqN[i*7 +: IDX];
                iss_hit[slot] = 1'b1;
                iss_nm[slot]  = IN_uopNmDst[i*5 +: 5];
                iss_tag[slot] = IN_uopTagDst[i*7 +: 7];
            end
        end
        for (int p = 0; p < WIDTH_WB; p++) begin
            if (IN_wbValid[p]) begin
                slot         = IN_wbSqN[p*7 +: IDX];
                wb_hit[slot] = 1'b1;
            end
        end
        for (int k = 0; k < WIDTH_COMMIT; k++) begin
            if (com_ok[k]) begin
                ret_hit[com_sqn[k][IDX-1:0]] = 1'b1;
            end
        end
    end

    // A slot's sqN is recovered from its distance to the oldest entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [IDX-1:0] offset;
        logic [6:0]     entry_sqn;
        assign offset      = IDX'(gi) - base_sqn_reg[IDX-1:0];
        assign entry_sqn   = base_sqn_reg + 7'(offset);
        assign squash[gi]  = IN_branchTaken && is_younger(entry_sqn, IN_branchSqN);
    end

    always_comb begin
        logic [6:0] used_next;
        next_sqn_next = next_sqn_reg;
        if (IN_branchTaken) begin
            next_sqn_next = IN_branchSqN + 7'd1;
        end else begin
            for (int i = 0; i < WIDTH_ISSUE; i++) begin
                if (IN_uopValid[i]) begin
                    next_sqn_next = IN_uopSqN[i*7 +: 7] + 7'd1;
                end
            end
        end
        base_sqn_next = base_sqn_reg + com_count;
        used_next     = next_sqn_next - base_sqn_next;
        stall_next    = (7'(DEPTH) - used_next) < 7'(WIDTH_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg     <= '0;
            done_reg      <= '0;
            base_sqn_reg  <= 7'd0;
            next_sqn_reg  <= 7'd0;
            stall_reg     <= 1'b0;
            com_valid_reg <= '0;
            com_nm_reg    <= '0;
            com_tag_reg   <= '0;
            com_sqn_reg   <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (!IN_branchTaken && iss_hit[e]) begin
                    valid_reg[e] <= 1'b1;
                    done_reg[e]  <= 1'b0;
                end else begin
                    if (ret_hit[e] || squash[e]) begin
                        valid_reg[e] <= 1'b0;
                    end
                    if (wb_hit[e] && valid_reg[e]) begin
                        done_reg[e] <= 1'b1;
                    end
                end
            end
            for (int k = 0; k < WIDTH_COMMIT; k++) begin
                com_valid_reg[k]       <= com_ok[k];
                com_sqn_reg[k*7 +: 7]  <= com_ok[k] ? com_sqn[k] : 7'd0;
                com_nm_reg[k*5 +: 5]   <= com_ok[k] ? nm_mem[com_sqn[k][IDX-1:0]] : 5'd0;
                com_tag_reg[k*7 +: 7]  <= com_ok[k] ? tag_mem[com_sqn[k][IDX-1:0]] : 7'd0;
            end
            base_sqn_reg <= base_sqn_next;
            next_sqn_reg <= next_sqn_next;
            stall_reg    <= stall_next;
        end
    end

    // Payload storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (!rst && !IN_branchTaken && iss_hit[e]) begin
                nm_mem[e]  <= iss_nm[e];
                tag_mem[e] <= iss_tag[e];
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_committed_reg;
    logic [31:0] perf_flushes_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_committed_reg <= 32'd0;
            perf_flushes_reg   <= 32'd0;
        end else begin
            perf_committed_reg <= perf_committed_reg + 32'(com_count);
            perf_flushes_reg   <= perf_flushes_reg + 32'(IN_branchTaken);
        end
    end

    assign OUT_perfCommitted = perf_committed_reg;
    assign OUT_perfFlushes   = perf_flushes_reg;
`endif

    assign OUT_comValid  = com_valid_reg;
    assign OUT_comNmDst  = com_nm_reg;
    assign OUT_comTagDst = com_tag_reg;
    assign OUT_comSqN    = com_sqn_reg;
    assign OUT_maxSqN    = base_sqn_reg + 7'(DEPTH - 1);
    assign OUT_stall     = stall_reg;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
In-order retirement buffer on the far side of the rename stage's commit interface. It accepts renamed uops tagged with sequence numbers (sqN) and marks them complete on writeback. Each cycle it retires up to WIDTH_COMMIT oldest completed uops in order, driving the commit stream (architectural dest, physical tag, sqN) that the rename table and tag buffer consume. It also squashes entries younger than a mispredicted branch.

Parameters:
DEPTH, 64, number of entries; power of two, at most 64 (sqN is 7 bits, slot index = sqN[log2(DEPTH)-1:0])
WIDTH_ISSUE, 4, uops accepted per cycle
WIDTH_WB, 4, writeback ports
WIDTH_COMMIT, 4, max uops retired per cycle

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
IN_uopValid  in  WIDTH_ISSUE  per-slot issue valid
IN_uopSqN  in  WIDTH_ISSUE*7  sqN of each issued uop
IN_uopNmDst  in  WIDTH_ISSUE*5  architectural dest register; 0 = none
IN_uopTagDst  in  WIDTH_ISSUE*7  physical tag; bit 6 set = immediate/no physical reg
IN_wbValid  in  WIDTH_WB  writeback valid
IN_wbSqN  in  WIDTH_WB*7  sqN being completed
IN_branchTaken  in  1  mispredict flush this cycle
IN_branchSqN  in  7  sqN of mispredicted branch; entries younger than it are squashed
OUT_comValid  out  WIDTH_COMMIT  commit slot valid
OUT_comNmDst  out  WIDTH_COMMIT*5  committed architectural dest
OUT_comTagDst  out  WIDTH_COMMIT*7  committed physical tag
OUT_comSqN  out  WIDTH_COMMIT*7  committed sqN
OUT_maxSqN  out  7  baseSqN + DEPTH - 1; newest sqN rename may issue
OUT_stall  out  1  fewer than WIDTH_ISSUE free entries

Behaviour:
- State per entry: valid, done, nmDst[5], tagDst[7]. Global state: baseSqN[7] (oldest uncommitted) and nextSqN[7] (one past newest issued).
- Reset: all entries valid=0 and done=0; baseSqN=0; nextSqN=0; OUT_comValid=0; OUT_comNmDst, OUT_comTagDst and OUT_comSqN=0; OUT_stall=0; OUT_maxSqN=DEPTH-1 one cycle after rst deasserts.
- Issue: for each i with IN_uopValid[i] and !IN_branchTaken, write entry at IN_uopSqN[i] with valid=1, done=0, and the given dest and tag. nextSqN becomes the highest issued sqN + 1. Issue lanes are compacted and use ascending sqN.
- Writeback: for each port with IN_wbValid, set done=1 on the addressed slot only if that slot is valid. Writebacks to free or committed slots are ignored. Multiple ports hitting the same slot are harmless.
- Issue and writeback to the same slot in the same cycle: issue wins, done=0.
- Commit, combinational scan for k=0..WIDTH_COMMIT-1:
  - slot k is baseSqN+k;
  - it commits if valid && done, all lower k committed, and (!IN_branchTaken || $signed(sqN - IN_branchSqN) <= 0);
  - the scan stops at the first failure.
- Commit outputs are registered: 1-cycle latency from the done=1 write to OUT_comValid. Retired entries get valid=0, and baseSqN advances by the commit count in the same edge.
- Flush: when IN_branchTaken, clear valid on every entry with $signed(entrySqN - IN_branchSqN) > 0, and set nextSqN = IN_branchSqN+1. Issue is ignored that cycle. Writebacks to surviving entries still apply.
- Free count = DEPTH - (nextSqN - baseSqN), mod 128. OUT_stall is registered and equals (free count after this edge's updates) < WIDTH_ISSUE.
- Full: with free = 0, issue must not occur (rename honours OUT_stall). If it does, behaviour is undefined, with no assertion.
- Wrap: all sqN arithmetic is 7-bit modulo. Slot index wraps at DEPTH.
- rst during any activity overrides issue, writeback, flush and commit in that cycle.

Optional Feature:
ROB_PERF_CNT_EN
- Defined: adds output OUT_perfCommitted[32] (total uops retired) and OUT_perfFlushes[32] (IN_branchTaken cycles). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist. Commit behaviour is identical in both builds.

Test Plan:
- Reset then issue sqN 0..3, writeback 0..3 in one cycle -> next cycle OUT_comValid=4'b1111, OUT_comSqN=0,1,2,3; OUT_maxSqN=67 (4+63) after.
- Issue sqN 0..3, writeback only 0,1,3 -> commit sqN 0,1 only. Writeback 2 later -> next cycle commits 2,3 in slots 0,1.
- Issue sqN 0..7, all done, IN_branchTaken with IN_branchSqN=2 -> commits 0..2 only; entries 3..7 invalid; nextSqN=3; a later writeback to sqN 5 has no effect.
- Fill to 61 outstanding entries, DEPTH=64 -> OUT_stall=1. Commit 1 -> free=4, OUT_stall=0.
- Run sqN across 127->0 wrap with commits and a flush at IN_branchSqN=126 -> ordering and squash by signed compare remain correct.
- Issue to slot k with a same-cycle writeback to k -> entry done=0, no commit until a later writeback.
